// File: rtl/ahb_manager_cmd_seq.sv
// Command sequencer for the ahb_manager user interface: unrolls whole-burst
// commands into per-beat requests and inserts BUSY/IDLE beats on write-data underrun.
`timescale 1ns/1ps
module ahb_manager_cmd_seq #(
  parameter int DATA_WDT = 32
) (
  input  logic                i_hclk,
  input  logic                i_hreset,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic                i_cmd_wr,
  input  logic [31:0]         i_cmd_addr,
  input  logic [15:0]         i_cmd_len,
  input  logic [2:0]          i_cmd_size,
  input  logic [31:0]         i_cmd_mask,
  input  logic                i_wdata_valid,
  output logic                o_wdata_ready,
  input  logic [DATA_WDT-1:0] i_wdata,
  output logic                o_idle,
  output logic                o_wr,
  output logic                o_rd,
  output logic [DATA_WDT-1:0] o_wr_data,
  output logic [31:0]         o_addr,
  output logic [31:0]         o_mask,
  output logic [2:0]          o_size,
  output logic [15:0]         o_min_len,
  output logic                o_first_xfer,
  input  logic                i_stall,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_cmd_err
);

  localparam int MAX_SIZE = $clog2(DATA_WDT / 8);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      state;
  logic        cmd_ready_q;
  logic        done_q;
  logic        err_q;
  logic        first_q;
  logic        wr_q;
  logic [15:0] rem_q;
  logic [31:0] addr_q;
  logic [31:0] mask_q;
  logic [2:0]  size_q;

  logic run;
  logic beat;
  logic accept;
  logic cmd_take;

  // A command is legal when it has beats, fits the bus, and is size-aligned.
  function automatic logic cmd_legal(input logic [31:0] addr, input logic [15:0] len,
                                     input logic [2:0] size);
    logic [31:0] low_bits;
    low_bits = (32'd1 << size) - 32'd1;
    return (len != 16'd0) && ({29'd0, size} <= 32'(MAX_SIZE)) && ((addr & low_bits) == 32'd0);
  endfunction

  assign run      = (state == S_RUN);
  assign beat     = run & (~wr_q | i_wdata_valid);
  assign accept   = beat & ~i_stall;
  assign cmd_take = (state == S_IDLE) & i_cmd_valid & cmd_ready_q;

  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset) begin
      state       <= S_IDLE;
      cmd_ready_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      first_q     <= 1'b1;
      wr_q        <= 1'b0;
      rem_q       <= 16'd0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_take) begin
            if (cmd_legal(i_cmd_addr, i_cmd_len, i_cmd_size)) begin
              state       <= S_RUN;
              cmd_ready_q <= 1'b0;
              wr_q        <= i_cmd_wr;
              rem_q       <= i_cmd_len;
              first_q     <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (accept) begin
            first_q <= 1'b0;
            // rem stays at 1 on the final beat; the outputs are gated off in S_IDLE.
            if (rem_q == 16'd1) begin
              state       <= S_IDLE;
              done_q      <= 1'b1;
              cmd_ready_q <= 1'b1;
            end else begin
              rem_q <= rem_q - 16'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Command payload needs no reset: it is only visible while in S_RUN.
  always_ff @(posedge i_hclk) begin
    if (cmd_take) begin
      addr_q <= i_cmd_addr;
      mask_q <= i_cmd_mask;
      size_q <= i_cmd_size;
    end
  end

  assign o_cmd_ready   = cmd_ready_q;
  assign o_busy        = run;
  assign o_done        = done_q;
  assign o_cmd_err     = err_q;
  assign o_rd          = run & ~wr_q;
  assign o_wr          = run & wr_q & i_wdata_valid;
  assign o_wdata_ready = o_wr & ~i_stall;
  assign o_wr_data     = o_wr ? i_wdata : '0;
  // Underrun before the first beat must show IDLE, since BUSY may not precede NONSEQ.
  assign o_idle        = ~run | (wr_q & ~i_wdata_valid & first_q);
  assign o_first_xfer  = ~run | (beat & first_q);
  assign o_addr        = run ? addr_q : 32'd0;
  assign o_mask        = run ? mask_q : 32'd0;
  assign o_size        = run ? size_q : 3'd0;
  assign o_min_len     = run ? rem_q : 16'd0;

endmodule

// File: tb/tb_ahb_manager_cmd_seq.sv
// Bench for ahb_manager_cmd_seq: per-cycle comparison against a burst-level model,
// plus literal expectations for each directed scenario.
`timescale 1ns/1ps
module tb_ahb_manager_cmd_seq;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0, cmd_wr = 1'b0;
  logic [31:0]   cmd_addr = '0, cmd_mask = '0;
  logic [15:0]   cmd_len = '0;
  logic [2:0]    cmd_size = '0;
  logic          wdata_valid = 1'b0, stall = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic          o_cmd_ready, o_wdata_ready, o_idle, o_wr, o_rd, o_first_xfer;
  logic          o_busy, o_done, o_cmd_err;
  logic [DW-1:0] o_wr_data;
  logic [31:0]   o_addr, o_mask;
  logic [2:0]    o_size;
  logic [15:0]   o_min_len;

  ahb_manager_cmd_seq #(.DATA_WDT(DW)) dut (
    .i_hclk(clk), .i_hreset(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_wr(cmd_wr), .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len), .i_cmd_size(cmd_size),
    .i_cmd_mask(cmd_mask), .i_wdata_valid(wdata_valid), .o_wdata_ready(o_wdata_ready),
    .i_wdata(wdata), .o_idle(o_idle), .o_wr(o_wr), .o_rd(o_rd), .o_wr_data(o_wr_data),
    .o_addr(o_addr), .o_mask(o_mask), .o_size(o_size), .o_min_len(o_min_len),
    .o_first_xfer(o_first_xfer), .i_stall(stall), .o_busy(o_busy), .o_done(o_done),
    .o_cmd_err(o_cmd_err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Burst-level model: is a burst open, how many beats are left, is the next beat the first.
  bit          m_run = 0, m_rdy = 0, m_done = 0, m_err = 0, m_first = 1, m_wr = 0;
  logic [31:0] m_addr = '0, m_mask = '0;
  logic [2:0]  m_size = '0;
  int          m_left = 0;

  function automatic bit legal(logic [31:0] a, logic [15:0] l, logic [2:0] s);
    int bytes;
    bytes = 1 << s;
    return (l != 0) && (s <= 3) && ((a % bytes) == 0);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run <= 0; m_rdy <= 0; m_done <= 0; m_err <= 0; m_first <= 1; m_left <= 0;
    end else begin
      m_done <= 0;
      m_err  <= 0;
      if (!m_run) begin
        m_rdy <= 1;
        if (cmd_valid && m_rdy) begin
          if (legal(cmd_addr, cmd_len, cmd_size)) begin
            m_run <= 1; m_rdy <= 0; m_wr <= cmd_wr; m_addr <= cmd_addr;
            m_mask <= cmd_mask; m_size <= cmd_size; m_left <= int'(cmd_len); m_first <= 1;
          end else begin
            m_err <= 1;
          end
        end
      end else if ((!m_wr || wdata_valid) && !stall) begin
        m_first <= 0;
        m_left  <= m_left - 1;
        if (m_left == 1) begin
          m_run <= 0; m_done <= 1; m_rdy <= 1;
        end
      end
    end
  end

  // Logs of accepted beats and observed pulses, cleared by the stimulus per scenario.
  logic [15:0]   q_min[$];
  bit            q_fx[$];
  logic [DW-1:0] got_data[$];
  int            done_cnt = 0, err_cnt = 0, busy_beats = 0, idle_gaps = 0, stall_cyc = 0;

  logic e_wr, e_rd, e_idle;
  always @(negedge clk) begin
    e_rd   = m_run && !m_wr;
    e_wr   = m_run && m_wr && wdata_valid;
    e_idle = !m_run || (m_wr && !wdata_valid && m_first);
    chk("cmd_ready", o_cmd_ready, m_rdy);
    chk("busy", o_busy, m_run);
    chk("done", o_done, m_done);
    chk("cmd_err", o_cmd_err, m_err);
    chk("rd", o_rd, e_rd);
    chk("wr", o_wr, e_wr);
    chk("wdata_ready", o_wdata_ready, e_wr && !stall);
    chk("idle", o_idle, e_idle);
    chk("min_len", o_min_len, m_run ? 64'(m_left) : 64'd0);
    chk("addr", o_addr, m_run ? m_addr : 32'd0);
    chk("mask", o_mask, m_run ? m_mask : 32'd0);
    chk("size", o_size, m_run ? m_size : 3'd0);
    if (!m_run) chk("first_xfer_idle", o_first_xfer, 1);
    else if (e_rd || e_wr) chk("first_xfer_beat", o_first_xfer, m_first);
    else if (!e_idle) chk("first_xfer_busy", o_first_xfer, 0);
    if (e_wr) chk("wr_data", o_wr_data, wdata);
    if ((o_rd || o_wr) && !stall) begin
      q_min.push_back(o_min_len);
      q_fx.push_back(o_first_xfer);
    end
    if (o_wr && !stall) got_data.push_back(o_wr_data);
    if ((o_rd || o_wr) && stall) stall_cyc++;
    if (o_busy && !o_wr && !o_rd && !o_idle) busy_beats++;
    if (o_busy && o_idle) idle_gaps++;
    if (o_done) done_cnt++;
    if (o_cmd_err) err_cnt++;
  end

  task automatic clear_logs();
    q_min.delete(); q_fx.delete(); got_data.delete();
    done_cnt = 0; err_cnt = 0; busy_beats = 0; idle_gaps = 0; stall_cyc = 0;
  endtask

  task automatic send_cmd(input bit wr, input logic [31:0] a, input logic [15:0] l,
                          input logic [2:0] s, input logic [31:0] mk);
    int t;
    cmd_valid = 1; cmd_wr = wr; cmd_addr = a; cmd_len = l; cmd_size = s; cmd_mask = mk;
    t = 0;
    while (t < 50) begin
      @(negedge clk);
      if (o_cmd_ready) break;
      t++;
    end
    if (t >= 50) chk("cmd_handshake_timeout", 0, 1);
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  logic [DW-1:0] wbase = '0;
  // Drives one burst until o_done; gap/stl bit c withholds data / stalls in cycle c.
  task automatic drive_burst(input bit wr, input int n, input logic [63:0] gap,
                             input logic [63:0] stl);
    int c, sent;
    bit acc, fin;
    c = 0; sent = 0; fin = 0;
    while (!fin && c < 4 * n + 100) begin
      wdata_valid = wr && (sent < n) && !((c < 64) && gap[c % 64]);
      wdata       = wbase + DW'(sent);
      stall       = (c < 64) && stl[c % 64];
      @(negedge clk);
      acc = o_wdata_ready;
      fin = o_done;
      @(posedge clk); #1;
      if (acc) sent++;
      c++;
    end
    wdata_valid = 0; stall = 0;
    if (!fin) chk("done_timeout", 0, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_idle", o_idle, 1);
    chk("rst_first_xfer", o_first_xfer, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_cmd_ready", o_cmd_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;

    // Scenario 1: read len=4 size=2 at 0x100.
    clear_logs();
    send_cmd(0, 32'h100, 16'd4, 3'd2, 32'h0000_000F);
    drive_burst(0, 4, 64'd0, 64'd0);
    chk("s1_beats", q_min.size(), 4);
    for (int i = 0; i < 4 && i < q_min.size(); i++) begin
      chk("s1_min_len", q_min[i], 64'(4 - i));
      chk("s1_first_xfer", q_fx[i], (i == 0) ? 1 : 0);
    end
    chk("s1_done_cnt", done_cnt, 1);

    // Scenario 2: write len=3 with a data gap after beat 0 -> one BUSY cycle.
    clear_logs();
    wbase = 64'hA000;
    send_cmd(1, 32'h200, 16'd3, 3'd3, 32'h0);
    drive_burst(1, 3, 64'b10, 64'd0);
    chk("s2_busy_beats", busy_beats, 1);
    chk("s2_writes", got_data.size(), 3);
    for (int i = 0; i < 3 && i < got_data.size(); i++)
      chk("s2_data_order", got_data[i], 64'hA000 + 64'(i));
    chk("s2_done_cnt", done_cnt, 1);

    // Scenario 2b: underrun before the first beat shows IDLE, not BUSY.
    clear_logs();
    wbase = 64'hC000;
    send_cmd(1, 32'h208, 16'd2, 3'd3, 32'h0);
    drive_burst(1, 2, 64'b1, 64'd0);
    chk("s2b_busy_beats", busy_beats, 0);
    chk("s2b_idle_gaps", idle_gaps, 1);
    chk("s2b_writes", got_data.size(), 2);

    // Scenario 3: stall 5 cycles mid-burst.
    clear_logs();
    send_cmd(0, 32'h40, 16'd6, 3'd3, 32'h0000_00FF);
    drive_burst(0, 6, 64'd0, 64'b111_1100);
    chk("s3_stall_cycles", stall_cyc, 5);
    chk("s3_beats", q_min.size(), 6);
    for (int i = 0; i < 6 && i < q_min.size(); i++) chk("s3_min_len", q_min[i], 64'(6 - i));
    chk("s3_done_cnt", done_cnt, 1);

    // Scenario 4: illegal commands are rejected with a one-cycle error pulse.
    clear_logs();
    send_cmd(0, 32'h100, 16'd0, 3'd2, 32'h0);
    chk("s4_len0_err", o_cmd_err, 1);
    chk("s4_len0_busy", o_busy, 0);
    send_cmd(0, 32'h102, 16'd4, 3'd2, 32'h0);
    chk("s4_unaligned_err", o_cmd_err, 1);
    chk("s4_unaligned_busy", o_busy, 0);
    send_cmd(0, 32'h100, 16'd1, 3'd4, 32'h0);
    chk("s4_size_err", o_cmd_err, 1);
    @(posedge clk); #1;
    chk("s4_err_pulse_width", o_cmd_err, 0);
    send_cmd(0, 32'h108, 16'd1, 3'd3, 32'h0);
    chk("s4_widest_accepted", o_busy, 1);
    drive_burst(0, 1, 64'd0, 64'd0);
    chk("s4_err_cnt", err_cnt, 3);
    chk("s4_done_cnt", done_cnt, 1);

    // Scenario 5: asynchronous reset during beat 2 of a len=8 write.
    clear_logs();
    wbase = 64'hB000;
    send_cmd(1, 32'h300, 16'd8, 3'd2, 32'h0);
    wdata_valid = 1; wdata = 64'hB000;
    @(posedge clk); #1 wdata = 64'hB001;
    @(posedge clk); #1 wdata = 64'hB002;
    rst = 1;
    #1;
    chk("s5_idle", o_idle, 1);
    chk("s5_first_xfer", o_first_xfer, 1);
    chk("s5_busy", o_busy, 0);
    chk("s5_wr", o_wr, 0);
    chk("s5_min_len", o_min_len, 0);
    wdata_valid = 0;
    @(posedge clk); #1 rst = 0;
    chk("s5_writes_before_reset", got_data.size(), 2);
    clear_logs();
    send_cmd(0, 32'h10, 16'd2, 3'd1, 32'h0);
    drive_burst(0, 2, 64'd0, 64'd0);
    chk("s5_after_beats", q_min.size(), 2);
    chk("s5_after_done", done_cnt, 1);

    // Scenario 6: maximum-length read.
    clear_logs();
    send_cmd(0, 32'h1000, 16'hFFFF, 3'd3, 32'h0);
    drive_burst(0, 65535, 64'd0, 64'd0);
    chk("s6_beats", q_min.size(), 65535);
    if (q_min.size() > 0) begin
      chk("s6_first_min_len", q_min[0], 65535);
      chk("s6_last_min_len", q_min[q_min.size() - 1], 1);
      chk("s6_first_xfer", q_fx[0], 1);
    end
    chk("s6_done_cnt", done_cnt, 1);

    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
